// File: rtl/timer_pwm_core.sv
// timer_pwm_core
// Counter engine of the timer/PWM peripheral. Runs either a one-shot timer
// or a free-running PWM generator. Control comes from the register bank.
// Status goes back to the register bank, which samples timer_done and
// overflow every cycle.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   enable      run request (level); dropping it returns to IDLE and clears flags
//   mode_pwm    0 = one-shot timer, 1 = PWM (latched at IDLE->RUN only)
//   period      cycles per period (0 behaves as 1)
//   duty        high cycles per PWM period
//   pwm_out     registered PWM waveform
//   timer_done  one-shot complete, level
//   overflow    sticky PWM wrap flag, level
//   count       current counter value
//
// Build option: TIMER_PWM_CORE_SHADOW_EN
//   defined     : period/duty are captured at IDLE->RUN and at each PWM wrap,
//                 so mid-period writes land glitch-free at the next wrap.
//   not defined : the live period/duty inputs are used every cycle. Lowering
//                 period below the current count lets the counter run to
//                 all-ones and wrap naturally (known hazard).
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | stopped; count and all flags 0; waits for enable
// RUN   | counting; wraps (PWM) or finishes (one-shot) at per_eff-1
// DONE  | one-shot finished; count holds, timer_done held high

module timer_pwm_core #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic                 mode_pwm,
    input  logic [CNT_WIDTH-1:0] period,
    input  logic [CNT_WIDTH-1:0] duty,
    output logic                 pwm_out,
    output logic                 timer_done,
    output logic                 overflow,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]           state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 pwm_q, pwm_d;
    logic                 done_q, done_d;
    logic                 ovf_q, ovf_d;
    logic                 mode_sh_q, mode_sh_d;

    logic [CNT_WIDTH-1:0] per_src;
    logic [CNT_WIDTH-1:0] duty_src;
    logic [CNT_WIDTH-1:0] per_eff;
    logic                 terminal;
    logic                 start;
    logic                 wrap;

    // A zero period is treated as one so the terminal compare never
    // underflows; comparing against per_eff-1 avoids any overflowing add.
    assign per_eff  = (per_src == CNT_ZERO) ? CNT_ONE : per_src;
    assign terminal = (count_q == (per_eff - CNT_ONE));
    assign start    = (state_q == ST_IDLE) && enable;
    assign wrap     = (state_q == ST_RUN) && enable && mode_sh_q && terminal;

`ifdef TIMER_PWM_CORE_SHADOW_EN
    logic [CNT_WIDTH-1:0] per_sh_q, per_sh_d;
    logic [CNT_WIDTH-1:0] duty_sh_q, duty_sh_d;

    always_comb begin
        per_sh_d  = per_sh_q;
        duty_sh_d = duty_sh_q;
        if (start || wrap) begin
            per_sh_d  = period;
            duty_sh_d = duty;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_sh_q  <= '0;
            duty_sh_q <= '0;
        end else begin
            per_sh_q  <= per_sh_d;
            duty_sh_q <= duty_sh_d;
        end
    end

    assign per_src  = per_sh_q;
    assign duty_src = duty_sh_q;
`else
    assign per_src  = period;
    assign duty_src = duty;
`endif

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        pwm_d     = 1'b0;
        done_d    = done_q;
        ovf_d     = ovf_q;
        mode_sh_d = mode_sh_q;

        // Dropping enable wins over any terminal-count action this cycle.
        if (!enable) begin
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
            done_d  = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d   = ST_RUN;
                    count_d   = CNT_ZERO;
                    done_d    = 1'b0;
                    ovf_d     = 1'b0;
                    mode_sh_d = mode_pwm;
                end
                ST_RUN: begin
                    // Registered compare: pwm_out lags count by one cycle.
                    pwm_d = mode_sh_q && (count_q < duty_src);
                    if (terminal) begin
                        if (mode_sh_q) begin
                            count_d = CNT_ZERO;
                            ovf_d   = 1'b1;
                        end else begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        count_d = count_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    done_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    count_d = CNT_ZERO;
                    done_d  = 1'b0;
                    ovf_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            pwm_q     <= 1'b0;
            done_q    <= 1'b0;
            ovf_q     <= 1'b0;
            mode_sh_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            pwm_q     <= pwm_d;
            done_q    <= done_d;
            ovf_q     <= ovf_d;
            mode_sh_q <= mode_sh_d;
        end
    end

    assign count      = count_q;
    assign pwm_out    = pwm_q;
    assign timer_done = done_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_timer_pwm_core.sv
// Self-checking bench for timer_pwm_core: reset state, a table of directed
// vectors, hand-written multi-cycle sequences, and randomized episodes
// checked against an arithmetic reference model.

module tb_timer_pwm_core;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        mode_pwm;
    logic [31:0] period;
    logic [31:0] duty;
    logic        pwm_out;
    logic        timer_done;
    logic        overflow;
    logic [31:0] count;

    int n_checks;
    int n_fail;

    timer_pwm_core #(.CNT_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .mode_pwm   (mode_pwm),
        .period     (period),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .timer_done (timer_done),
        .overflow   (overflow),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        mode;
        logic [31:0] per;
        logic [31:0] dty;
        int          cyc;     // edges after the enable edge E0
        logic [31:0] e_cnt;
        logic        e_pwm;
        logic        e_done;
        logic        e_ovf;
    } vec_t;

    vec_t vecs[15];

    // reference model state
    bit m_run;
    int m_j;
    bit m_mode;
    int m_p;
    int m_d;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] c, input logic p,
                           input logic d, input logic o);
        chk({tag, ".count"}, count, c);
        chk({tag, ".pwm_out"}, {31'd0, pwm_out}, {31'd0, p});
        chk({tag, ".timer_done"}, {31'd0, timer_done}, {31'd0, d});
        chk({tag, ".overflow"}, {31'd0, overflow}, {31'd0, o});
    endtask

    // Model update for one clock edge, given the enable value the DUT sampled.
    task automatic model_step(input bit en);
        if (!en) begin
            m_run = 1'b0;
        end else if (!m_run) begin
            m_run  = 1'b1;
            m_j    = 0;
            m_mode = mode_pwm;
            m_p    = int'(period);
            m_d    = int'(duty);
        end else begin
            m_j++;
        end
    endtask

    task automatic model_check(input string tag);
        int          pe;
        logic [31:0] c;
        logic        p, d, o;
        c = 0; p = 0; d = 0; o = 0;
        if (m_run) begin
            pe = (m_p == 0) ? 1 : m_p;
            if (m_mode) begin
                c = 32'(m_j % pe);
                p = (m_j >= 1) && (((m_j - 1) % pe) < m_d);
                o = (m_j >= pe);
            end else begin
                c = 32'((m_j < pe - 1) ? m_j : pe - 1);
                d = (m_j >= pe);
            end
        end
        chk_all(tag, c, p, d, o);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        mode_pwm = 1'b0;
        period   = 32'd0;
        duty     = 32'd0;

        //            mode  per     duty   cyc cnt    pwm   done  ovf
        vecs[0]  = '{1'b0, 32'd5,  32'd0,  4,  32'd4, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 32'd5,  32'd0,  5,  32'd4, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 32'd5,  32'd0,  9,  32'd4, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 32'd0,  32'd0,  0,  32'd0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 32'd0,  32'd0,  1,  32'd0, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 32'd10, 32'd3,  1,  32'd1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 32'd10, 32'd3,  4,  32'd4, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b1, 32'd10, 32'd3,  10, 32'd0, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 32'd10, 32'd3,  11, 32'd1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 32'd10, 32'd0,  5,  32'd5, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 32'd10, 32'd12, 10, 32'd0, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b1, 32'd0,  32'd1,  3,  32'd0, 1'b1, 1'b0, 1'b1};
        vecs[12] = '{1'b1, 32'd0,  32'd0,  3,  32'd0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 32'd1,  32'd5,  0,  32'd0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b0, 32'd1,  32'd0,  1,  32'd0, 1'b0, 1'b1, 1'b0};

        // reset state
        #2;
        chk_all("reset", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("idle", 32'd0, 1'b0, 1'b0, 1'b0);

        // directed vectors
        for (int v = 0; v < 15; v++) begin
            enable   = 1'b0;
            mode_pwm = vecs[v].mode;
            period   = vecs[v].per;
            duty     = vecs[v].dty;
            tick();
            enable = 1'b1;
            tick();
            for (int k = 0; k < vecs[v].cyc; k++) tick();
            chk_all($sformatf("vec%0d", v), vecs[v].e_cnt, vecs[v].e_pwm,
                    vecs[v].e_done, vecs[v].e_ovf);
        end

        // period lowered from 10 to 4 at count 2
        enable = 1'b0; mode_pwm = 1'b1; period = 32'd10; duty = 32'd3;
        tick();
        enable = 1'b1;
        tick(); tick(); tick();
        chk("shadow.count_e2", count, 32'd2);
        period = 32'd4;
        tick();
        chk("shadow.count_e3", count, 32'd3);
        tick();
`ifdef TIMER_PWM_CORE_SHADOW_EN
        chk_all("shadow.e4", 32'd4, 1'b0, 1'b0, 1'b0);
        repeat (6) tick();
        chk_all("shadow.e10", 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("shadow.count_e13", count, 32'd3);
        tick();
        chk("shadow.count_e14", count, 32'd0);
`else
        chk_all("live.e4", 32'd0, 1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        chk("live.count_e7", count, 32'd3);
        tick();
        chk("live.count_e8", count, 32'd0);
`endif

        // disable at count 6 after a wrap, then restart as one-shot
        enable = 1'b0; mode_pwm = 1'b1; period = 32'd10; duty = 32'd3;
        tick();
        enable = 1'b1;
        tick();
        repeat (16) tick();
        chk_all("dis.before", 32'd6, 1'b0, 1'b0, 1'b1);
        enable = 1'b0;
        tick();
        chk_all("dis.after", 32'd0, 1'b0, 1'b0, 1'b0);
        mode_pwm = 1'b0; period = 32'd3;
        enable = 1'b1;
        tick();
        chk_all("restart.e0", 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) tick();
        chk_all("restart.e3", 32'd2, 1'b0, 1'b1, 1'b0);
        period = 32'd100; duty = 32'd50; mode_pwm = 1'b1;
        repeat (3) tick();
        chk_all("done.hold", 32'd2, 1'b0, 1'b1, 1'b0);

        // asynchronous reset in the middle of a PWM run
        enable = 1'b0; mode_pwm = 1'b1; period = 32'd10; duty = 32'd3;
        tick();
        enable = 1'b1;
        tick();
        repeat (3) tick();
        chk_all("arst.before", 32'd3, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("arst.async", 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("arst.held", 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all("arst.e0", 32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_all("arst.e1", 32'd1, 1'b1, 1'b0, 1'b0);

        // randomized episodes against the reference model
        enable = 1'b0;
        tick();
        m_run = 1'b0; m_j = 0; m_mode = 1'b0; m_p = 0; m_d = 0;
        for (int ep = 0; ep < 150; ep++) begin
            int len;
            int off;
            period   = 32'($urandom_range(0, 12));
            duty     = 32'($urandom_range(0, 14));
            mode_pwm = 1'($urandom_range(0, 1));
            len      = $urandom_range(1, 30);
            off      = $urandom_range(1, 3);
            for (int c = 0; c < len; c++) begin
                enable = 1'b1;
                if (c > 0 && $urandom_range(0, 3) == 0) mode_pwm = ~mode_pwm;
                tick();
                model_step(1'b1);
                model_check($sformatf("rnd%0d.c%0d", ep, c));
            end
            for (int c = 0; c < off; c++) begin
                enable = 1'b0;
                tick();
                model_step(1'b0);
                model_check($sformatf("rnd%0d.off%0d", ep, c));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
